// File: rtl/instr_queue_dual_if.sv
// instr_queue_dual_if: push, pop and status bundle between decode, instr_queue_dual and issue.
interface instr_queue_dual_if #(
  parameter int DEPTH  = 8,
  parameter int DATA_W = 128
);
  logic                         flush_i;
  logic                         valid_i;
  logic [DATA_W-1:0]            data_1_i;
  logic [1:0]                   bid_1_i;
  logic                         valid_2_i;
  logic [DATA_W-1:0]            data_2_i;
  logic [1:0]                   bid_2_i;
  logic                         ready_o;
  logic                         pop_valid_o;
  logic [DATA_W-1:0]            pop_data_1_o;
  logic [1:0]                   pop_bid_1_o;
  logic                         pop_valid_2_o;
  logic [DATA_W-1:0]            pop_data_2_o;
  logic [1:0]                   pop_bid_2_o;
  logic                         pop_ready_i;
  logic                         pop_ready_2_i;
  logic [$clog2(DEPTH+1)-1:0]   count_o;
  modport master (
    output flush_i, valid_i, data_1_i, bid_1_i, valid_2_i, data_2_i, bid_2_i, pop_ready_i, pop_ready_2_i,
    input  ready_o, pop_valid_o, pop_data_1_o, pop_bid_1_o, pop_valid_2_o, pop_data_2_o, pop_bid_2_o, count_o
  );
  modport slave (
    input  flush_i, valid_i, data_1_i, bid_1_i, valid_2_i, data_2_i, bid_2_i, pop_ready_i, pop_ready_2_i,
    output ready_o, pop_valid_o, pop_data_1_o, pop_bid_1_o, pop_valid_2_o, pop_data_2_o, pop_bid_2_o, count_o
  );
endinterface

// File: rtl/instr_queue_dual.sv
// instr_queue_dual: 2-in/2-out circular instruction queue with single-cycle flush.
// Define IQ_BYPASS_EN to forward pushes straight to the pop outputs while the queue is empty.
module instr_queue_dual #(
  parameter int DEPTH  = 8,
  parameter int DATA_W = 128
) (
  input logic               clk,
  input logic               rst_n,
  instr_queue_dual_if.slave bus
);
  localparam int PW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH+1);
  localparam int EW = DATA_W + 2;
  logic [EW-1:0] r_mem [DEPTH];
  logic [PW-1:0] r_head, r_tail, w_head_1, w_tail_1;
  logic [CW-1:0] r_count;
  logic          w_ready, w_push_ok, w_s1_v, w_s2_v, w_byp, w_pv1, w_pv2;
  logic [EW-1:0] w_s1, w_s2, w_out1, w_out2, w_wr0;
  logic [1:0]    w_n_push, w_n_pop, w_skip, w_n_wr, w_n_rd;
  assign w_head_1  = r_head + PW'(1);
  assign w_tail_1  = r_tail + PW'(1);
  assign w_ready   = r_count <= CW'(DEPTH-2);
  assign w_push_ok = w_ready & ~bus.flush_i;
  // Compact the push slots so a lone slot-2 push lands at tail.
  assign w_s1_v    = bus.valid_i | bus.valid_2_i;
  assign w_s2_v    = bus.valid_i & bus.valid_2_i;
  assign w_s1      = bus.valid_i ? {bus.data_1_i, bus.bid_1_i} : {bus.data_2_i, bus.bid_2_i};
  assign w_s2      = {bus.data_2_i, bus.bid_2_i};
  assign w_n_push  = w_push_ok ? {1'b0, w_s1_v} + {1'b0, w_s2_v} : 2'd0;
`ifdef IQ_BYPASS_EN
  assign w_byp     = (r_count == '0) & ~bus.flush_i;
`else
  assign w_byp     = 1'b0;
`endif
  assign w_pv1     = ~bus.flush_i & (w_byp ? w_n_push != 2'd0 : r_count >= CW'(1));
  assign w_pv2     = ~bus.flush_i & (w_byp ? w_n_push == 2'd2 : r_count >= CW'(2));
  assign w_out1    = w_byp ? w_s1 : r_mem[r_head];
  assign w_out2    = w_byp ? w_s2 : r_mem[w_head_1];
  assign w_n_pop   = {1'b0, bus.pop_ready_i & w_pv1} + {1'b0, bus.pop_ready_i & bus.pop_ready_2_i & w_pv2};
  // Entries consumed straight off the bypass are never written and never leave storage.
  assign w_skip    = w_byp ? w_n_pop : 2'd0;
  assign w_n_wr    = w_n_push - w_skip;
  assign w_n_rd    = w_n_pop - w_skip;
  assign w_wr0     = w_skip[0] ? w_s2 : w_s1;
  always_ff @(posedge clk) begin
    if (w_n_wr != 2'd0) r_mem[r_tail] <= w_wr0;
    if (w_n_wr == 2'd2) r_mem[w_tail_1] <= w_s2;
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_head  <= '0;
      r_tail  <= '0;
      r_count <= '0;
    end else if (bus.flush_i) begin
      r_head  <= '0;
      r_tail  <= '0;
      r_count <= '0;
    end else begin
      r_head  <= r_head + PW'(w_n_rd);
      r_tail  <= r_tail + PW'(w_n_wr);
      r_count <= r_count + CW'(w_n_wr) - CW'(w_n_rd);
    end
  end
  assign bus.ready_o                      = w_ready;
  assign bus.pop_valid_o                  = w_pv1;
  assign bus.pop_valid_2_o                = w_pv2;
  assign {bus.pop_data_1_o, bus.pop_bid_1_o} = w_out1;
  assign {bus.pop_data_2_o, bus.pop_bid_2_o} = w_out2;
  assign bus.count_o                      = r_count;
  a_push_when_full: assert property (@(posedge clk) disable iff (!rst_n)
    !(~w_ready & (bus.valid_i | bus.valid_2_i)));
endmodule

// File: tb/tb_instr_queue_dual.sv
// tb_instr_queue_dual: directed and random traffic against a queue-based scoreboard.
module tb_instr_queue_dual;
  localparam int DEPTH = 8;
  localparam int DW    = 128;
`ifdef IQ_BYPASS_EN
  localparam bit BYP = 1'b1;
`else
  localparam bit BYP = 1'b0;
`endif
  typedef logic [DW+1:0] ent_t;
  logic clk = 1'b0;
  logic rst_n = 1'b1;
  ent_t sb[$];
  int checks = 0;
  int errors = 0;
  always #5 clk = ~clk;
  instr_queue_dual_if #(.DEPTH(DEPTH), .DATA_W(DW)) iq ();
  instr_queue_dual #(.DEPTH(DEPTH), .DATA_W(DW)) dut (.clk(clk), .rst_n(rst_n), .bus(iq.slave));

  task automatic chk(input string tag, input ent_t obs, input ent_t exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic drive_idle();
    iq.flush_i = 0; iq.valid_i = 0; iq.valid_2_i = 0; iq.data_1_i = '0; iq.data_2_i = '0;
    iq.bid_1_i = 0; iq.bid_2_i = 0; iq.pop_ready_i = 0; iq.pop_ready_2_i = 0;
  endtask

  // Called at posedge+1; drives one cycle, checks the pop side, updates the model, checks count.
  task automatic cycle(input logic v1, input logic [DW-1:0] d1, input logic [1:0] b1,
                       input logic v2, input logic [DW-1:0] d2, input logic [1:0] b2,
                       input logic pr1, input logic pr2, input logic fl);
    ent_t p[$];
    ent_t vis[$];
    int n;
    logic rdy;
    bit byp_case;
    iq.valid_i = v1; iq.data_1_i = d1; iq.bid_1_i = b1;
    iq.valid_2_i = v2; iq.data_2_i = d2; iq.bid_2_i = b2;
    iq.pop_ready_i = pr1; iq.pop_ready_2_i = pr2; iq.flush_i = fl;
    #1;
    rdy = (DEPTH - sb.size()) >= 2;
    chk("ready", ent_t'(iq.ready_o), ent_t'(rdy));
    if (rdy && !fl) begin
      if (v1) p.push_back({d1, b1});
      if (v2) p.push_back({d2, b2});
    end
    byp_case = BYP && sb.size() == 0 && !fl;
    if (byp_case) vis = p; else vis = sb;
    chk("pop_valid", ent_t'(iq.pop_valid_o), ent_t'(vis.size() >= 1 && !fl));
    chk("pop_valid_2", ent_t'(iq.pop_valid_2_o), ent_t'(vis.size() >= 2 && !fl));
    if (!fl && vis.size() >= 1) chk("pop_1", {iq.pop_data_1_o, iq.pop_bid_1_o}, vis[0]);
    if (!fl && vis.size() >= 2) chk("pop_2", {iq.pop_data_2_o, iq.pop_bid_2_o}, vis[1]);
    n = fl ? 0 : int'(pr1 && vis.size() >= 1) + int'(pr1 && pr2 && vis.size() >= 2);
    for (int i = 0; i < n; i++) void'(vis.pop_front());
    sb = vis;
    if (fl) sb.delete();
    else if (!byp_case) foreach (p[i]) sb.push_back(p[i]);
    @(posedge clk);
    #1;
    drive_idle();
    chk("count", ent_t'(iq.count_o), ent_t'(sb.size()));
  endtask

  task automatic push2(input logic [DW-1:0] d1, input logic [DW-1:0] d2, input logic pr1, input logic pr2);
    cycle(1, d1, d1[1:0], 1, d2, d2[1:0], pr1, pr2, 0);
  endtask

  task automatic pop(input logic pr1, input logic pr2);
    cycle(0, '0, 0, 0, '0, 0, pr1, pr2, 0);
  endtask

  initial begin
    logic v1, v2, fl, pr1, pr2;
    logic [DW-1:0] d1, d2;
    drive_idle();
    #1 rst_n = 0;
    #1;
    chk("rst_count", ent_t'(iq.count_o), 0);
    chk("rst_pop_valid", ent_t'(iq.pop_valid_o), 0);
    chk("rst_pop_valid_2", ent_t'(iq.pop_valid_2_o), 0);
    chk("rst_ready", ent_t'(iq.ready_o), 1);
    repeat (2) @(posedge clk);
    @(negedge clk) rst_n = 1;
    @(posedge clk);
    #1;
    for (int i = 0; i < 4; i++) push2(DW'(2*i), DW'(2*i+1), 0, 0);
    chk("full_count", ent_t'(iq.count_o), 8);
    chk("full_ready", ent_t'(iq.ready_o), 0);
    pop(1, 0);
    chk("cnt7_ready", ent_t'(iq.ready_o), 0);
    pop(1, 1);
    pop(1, 1);
    pop(0, 1);
    chk("pr2_only_count", ent_t'(iq.count_o), 3);
    pop(1, 1);
    pop(1, 1);
    chk("cnt1_dual_pop", ent_t'(iq.count_o), 0);
    pop(1, 1);
    cycle(0, '0, 0, 1, DW'('hA5), 2, 0, 0, 0);
    chk("a5_valid", ent_t'(iq.pop_valid_o), 1);
    chk("a5_data", ent_t'(iq.pop_data_1_o), ent_t'('hA5));
    chk("a5_bid", ent_t'(iq.pop_bid_1_o), 2);
    chk("a5_valid_2", ent_t'(iq.pop_valid_2_o), 0);
    pop(1, 0);
    for (int i = 0; i < 3; i++) push2(DW'('h200 + 2*i), DW'('h201 + 2*i), 0, 0);
    push2(DW'('h206), DW'('h207), 1, 1);
    chk("wrap_count", ent_t'(iq.count_o), 6);
    repeat (3) pop(1, 1);
    push2(DW'('h300), DW'('h301), 0, 0);
    push2(DW'('h302), DW'('h303), 0, 0);
    cycle(1, DW'('h304), 0, 0, '0, 0, 0, 0, 0);
    chk("pre_flush_count", ent_t'(iq.count_o), 5);
    cycle(1, DW'('h310), 1, 1, DW'('h311), 3, 1, 1, 1);
    chk("flush_count", ent_t'(iq.count_o), 0);
    chk("flush_pop_valid", ent_t'(iq.pop_valid_o), 0);
    chk("flush_ready", ent_t'(iq.ready_o), 1);
    push2(DW'('h400), DW'('h401), 1, 1);
`ifdef IQ_BYPASS_EN
    chk("bypass_count", ent_t'(iq.count_o), 0);
`endif
    pop(1, 1);
    push2(DW'('h500), DW'('h501), 0, 0);
    push2(DW'('h502), DW'('h503), 0, 0);
    #2 rst_n = 0;
    #1;
    chk("async_rst_count", ent_t'(iq.count_o), 0);
    chk("async_rst_pop_valid", ent_t'(iq.pop_valid_o), 0);
    chk("async_rst_ready", ent_t'(iq.ready_o), 1);
    sb.delete();
    @(negedge clk) rst_n = 1;
    @(posedge clk);
    #1;
    for (int i = 0; i < 400; i++) begin
      fl  = $urandom_range(0, 24) == 0;
      v1  = $urandom_range(0, 1);
      v2  = $urandom_range(0, 1);
      if ((DEPTH - sb.size()) < 2) begin v1 = 0; v2 = 0; end
      pr1 = $urandom_range(0, 2) != 0;
      pr2 = $urandom_range(0, 1);
      d1  = {$urandom(), $urandom(), $urandom(), $urandom()};
      d2  = {$urandom(), $urandom(), $urandom(), $urandom()};
      cycle(v1, d1, 2'($urandom_range(0, 3)), v2, d2, 2'($urandom_range(0, 3)), pr1, pr2, fl);
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
